pe_seq_ctrl: RTL and testbench

- Sequencer that runs a PE instruction stream against the single-cycle PE core and the 32x32 register file.
- Accepts 32-bit instruction words through a valid/ready queue.
- For each instruction: reads up to three source registers, issues one operation to the core, waits for the result with a timeout, then writes the result back to the destination register.
- Sits between the instruction source (test harness or future fetch unit) and the core/regfile pair. It replaces direct test-port driving.

---
 rtl/pe_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pe_seq_ctrl
// Description : Instruction queue plus read/issue/wait/writeback sequencer
//               between an instruction source and the PE core / regfile pair.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_seq_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr_data,
    input  logic        flush,
    output logic [4:0]  rf_rd_addr1,
    output logic [4:0]  rf_rd_addr2,
    input  logic [31:0] rf_rd_data1,
    input  logic [31:0] rf_rd_data2,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic        rf_wr_en,
    output logic [31:0] pe_opcode,
    output logic [31:0] pe_op1,
    output logic [31:0] pe_op2,
    output logic [31:0] pe_op3,
    output logic        pe_valid,
    input  logic [31:0] pe_result,
    input  logic        pe_result_valid,
    output logic        busy,
    output logic [15:0] retired,
    output logic        err_timeout
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_rd12  = 3'd1;
    localparam logic [2:0] c_st_rd3   = 3'd2;
    localparam logic [2:0] c_st_issue = 3'd3;
    localparam logic [2:0] c_st_wait  = 3'd4;
    localparam logic [2:0] c_st_wb    = 3'd5;

    logic [31:0]        r_mem [DEPTH];
    logic [c_ptr_w:0]   r_wr_ptr;
    logic [c_ptr_w:0]   r_rd_ptr;
    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [31:0]        r_ir;
    logic [31:0]        r_op1;
    logic [31:0]        r_op2;
    logic [31:0]        r_op3;
    logic [31:0]        r_result;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic [15:0]        r_retired;
    logic               r_err;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_timeout;
    logic               w_hold;
    logic [4:0]         w_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign w_push  = instr_valid && !w_full && !flush;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_rd      = r_ir[24:20];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= instr_data;
        end
    end

    // WB also pops the next instruction so back-to-back issues are 5 cycles apart.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!w_empty && !flush) begin
                    w_pop        = 1'b1;
                    w_state_next = c_st_rd12;
                end
            end
            c_st_rd12:  w_state_next = c_st_rd3;
            c_st_rd3:   w_state_next = c_st_issue;
            c_st_issue: w_state_next = c_st_wait;
            c_st_wait: begin
                if (pe_result_valid) begin
                    w_state_next = c_st_wb;
                end else if (w_cnt_inc == c_cnt_last) begin
                    w_timeout    = 1'b1;
                    w_state_next = c_st_idle;
                end
            end
            c_st_wb: begin
                if (!w_empty && !flush) begin
                    w_pop        = 1'b1;
                    w_state_next = c_st_rd12;
                end else begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_state   <= c_st_idle;
            r_ir      <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_op3     <= '0;
            r_result  <= '0;
            r_cnt     <= '0;
            r_retired <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_pop) r_ir <= r_mem[r_rd_ptr[c_ptr_w-1:0]];
            case (r_state)
                c_st_rd12: begin
                    r_op1 <= rf_rd_data1;
                    r_op2 <= rf_rd_data2;
                end
                c_st_rd3:   r_op3 <= rf_rd_data1;
                c_st_issue: r_cnt <= '0;
                c_st_wait: begin
                    if (pe_result_valid) r_result <= pe_result;
                    else                 r_cnt    <= w_cnt_inc;
                end
                c_st_wb:    r_retired <= r_retired + 16'd1;
                default: ;
            endcase
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign w_hold      = (r_state == c_st_issue) || (r_state == c_st_wait);
    assign instr_ready = !w_full;
    assign rf_rd_addr1 = (r_state == c_st_rd12) ? r_ir[19:15] :
                         (r_state == c_st_rd3)  ? r_ir[9:5]   : 5'd0;
    assign rf_rd_addr2 = (r_state == c_st_rd12) ? r_ir[14:10] : 5'd0;
    assign rf_wr_en    = (r_state == c_st_wb) && (w_rd != 5'd0);
    assign rf_wr_addr  = (r_state == c_st_wb) ? w_rd : 5'd0;
    assign rf_wr_data  = (r_state == c_st_wb) ? r_result : 32'd0;
    assign pe_valid    = (r_state == c_st_issue);
    assign pe_opcode   = w_hold ? r_ir  : 32'd0;
    assign pe_op1      = w_hold ? r_op1 : 32'd0;
    assign pe_op2      = w_hold ? r_op2 : 32'd0;
    assign pe_op3      = w_hold ? r_op3 : 32'd0;
    assign busy        = (r_state != c_st_idle) || !w_empty;
    assign retired     = r_retired;
    assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_seq_ctrl
// Description : Directed bench for pe_seq_ctrl with regfile model and stub core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_seq_ctrl;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic        flush;
    logic [4:0]  rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
    logic [31:0] rf_rd_data1, rf_rd_data2, rf_wr_data;
    logic        rf_wr_en;
    logic [31:0] pe_opcode, pe_op1, pe_op2, pe_op3;
    logic        pe_valid;
    logic [31:0] pe_result = 32'd0;
    logic        pe_result_valid = 1'b0;
    logic        busy;
    logic [15:0] retired;
    logic        err_timeout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int push_cyc;

    pe_seq_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .flush(flush),
        .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
        .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en),
        .pe_opcode(pe_opcode), .pe_op1(pe_op1), .pe_op2(pe_op2), .pe_op3(pe_op3),
        .pe_valid(pe_valid), .pe_result(pe_result), .pe_result_valid(pe_result_valid),
        .busy(busy), .retired(retired), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: combinational read, write on the clock edge.
    logic [31:0] rf [32] = '{default: 32'd0};
    assign rf_rd_data1 = rf[rf_rd_addr1];
    assign rf_rd_data2 = rf[rf_rd_addr2];
    always @(posedge clk) if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;

    // Stub core: result = op1+op2+op3+opcode[4:0]; mode 0 reply next cycle,
    // 1 hold the reply until mode returns to 0, 2 never reply.
    int          core_mode = 0;
    bit          spur = 1'b0;
    bit          pend = 1'b0;
    logic [31:0] pend_val = 32'd0;
    always @(negedge clk) begin
        pe_result_valid = 1'b0;
        pe_result       = 32'd0;
        if (spur) begin
            pe_result_valid = 1'b1;
            pe_result       = 32'hDEAD_BEEF;
        end else if (pend && core_mode == 0) begin
            pe_result_valid = 1'b1;
            pe_result       = pend_val;
            pend            = 1'b0;
        end
        if (pe_valid && core_mode != 2) begin
            pend     = 1'b1;
            pend_val = pe_op1 + pe_op2 + pe_op3 + {27'd0, pe_opcode[4:0]};
        end
    end

    // Issue / writeback / timeout monitor.
    int          n_iss = 0, n_wb = 0, err_cyc = -1;
    int          iss_cyc [64];
    logic [31:0] iss_opc [64], iss_op1 [64], iss_op2 [64], iss_op3 [64];
    int          wb_cyc [64];
    logic [4:0]  wb_addr [64];
    logic [31:0] wb_data [64];
    always @(negedge clk) begin
        if (pe_valid && n_iss < 64) begin
            iss_cyc[n_iss] = cyc;
            iss_opc[n_iss] = pe_opcode;
            iss_op1[n_iss] = pe_op1;
            iss_op2[n_iss] = pe_op2;
            iss_op3[n_iss] = pe_op3;
            n_iss++;
        end
        if (rf_wr_en && n_wb < 64) begin
            wb_cyc[n_wb]  = cyc;
            wb_addr[n_wb] = rf_wr_addr;
            wb_data[n_wb] = rf_wr_data;
            n_wb++;
        end
        if (err_timeout && err_cyc < 0) err_cyc = cyc;
    end

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2,
                                       input int rs3, input int imm);
        return {7'd0, 5'(rd), 5'(rs1), 5'(rs2), 5'(rs3), 5'(imm)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        bit ok;
        bit rdy;
        ok = 1'b0;
        instr_valid = 1'b1;
        instr_data  = w;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            rdy = instr_ready;
            @(posedge clk);
            #1;
            ok = rdy;
        end
        instr_valid = 1'b0;
        push_cyc = cyc;
        chk("push_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_ret(input string tag, input int target);
        int n;
        n = 0;
        while ({16'd0, retired} != 32'(target) && n < 300) begin
            tick(1);
            n++;
        end
        chk(tag, {16'd0, retired}, 32'(target));
    endtask

    task automatic wait_iss(input string tag, input int target);
        int n;
        n = 0;
        while (n_iss < target && n < 100) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(n_iss), 32'(target));
    endtask

    int ni, nw, pc, er;
    logic [31:0] w_c, w_g;

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr_data = 32'd0; flush = 1'b0;
        tick(2);
        chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_busy",        {31'd0, busy},        32'd0);
        chk("rst_pe_valid",    {31'd0, pe_valid},    32'd0);
        chk("rst_rf_wr_en",    {31'd0, rf_wr_en},    32'd0);
        chk("rst_retired",     {16'd0, retired},     32'd0);
        chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
        chk("rst_pe_opcode",   pe_opcode,            32'd0);
        rst_n = 1'b1;
        tick(2);

        // Preload r1=5, r2=7 through writebacks.
        push(mk(1, 0, 0, 0, 5));
        push(mk(2, 0, 0, 0, 7));
        wait_ret("preload_retired", 2);
        chk("preload_r1", rf[1], 32'd5);
        chk("preload_r2", rf[2], 32'd7);

        // r3 = r1 + r2, with latency measured from the push edge.
        ni = n_iss; nw = n_wb;
        w_c = mk(3, 1, 2, 0, 0);
        push(w_c);
        pc = push_cyc;
        wait_ret("add_retired", 3);
        chk("add_issue_lat", 32'(iss_cyc[ni] - pc), 32'd3);
        chk("add_opcode",    iss_opc[ni], w_c);
        chk("add_op1",       iss_op1[ni], 32'd5);
        chk("add_op2",       iss_op2[ni], 32'd7);
        chk("add_wb_lat",    32'(wb_cyc[nw] - pc), 32'd5);
        chk("add_wb_addr",   {27'd0, wb_addr[nw]}, 32'd3);
        chk("add_wb_data",   wb_data[nw], 32'd12);

        // Dependent pair: r4 = 5+7+1 = 13, then r5 = r4 + r1 + r3 = 13+5+12 = 30.
        ni = n_iss; nw = n_wb;
        push(mk(4, 1, 2, 0, 1));
        push(mk(5, 4, 1, 3, 0));
        wait_ret("dep_retired", 5);
        chk("dep_issue_gap", 32'(iss_cyc[ni + 1] - iss_cyc[ni]), 32'd5);
        chk("dep_b_op1",     iss_op1[ni + 1], 32'd13);
        chk("dep_b_op2",     iss_op2[ni + 1], 32'd5);
        chk("dep_b_op3",     iss_op3[ni + 1], 32'd12);
        chk("dep_b_wb_data", wb_data[nw + 1], 32'd30);

        // Stalled core with six instructions against a four-entry queue.
        core_mode = 1;
        nw = n_wb;
        for (int k = 0; k < 5; k++) push(mk(9 + k, 0, 0, 0, 9 + k));
        chk("stall_ready_full", {31'd0, instr_ready}, 32'd0);
        instr_valid = 1'b1;
        instr_data  = mk(14, 0, 0, 0, 14);
        tick(3);
        chk("stall_ready_held", {31'd0, instr_ready}, 32'd0);
        chk("stall_busy",       {31'd0, busy},        32'd1);
        core_mode = 0;
        push(mk(14, 0, 0, 0, 14));
        wait_ret("stall_retired", 11);
        tick(5);
        chk("stall_wb_count", 32'(n_wb - nw), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk("stall_wb_addr", {27'd0, wb_addr[nw + k]}, 32'(9 + k));
            chk("stall_wb_data", wb_data[nw + k], 32'(9 + k));
        end

        // Timeout on the first instruction, the queued one completes.
        core_mode = 2;
        ni = n_iss; nw = n_wb;
        w_g = mk(15, 1, 0, 0, 0);
        push(w_g);
        push(mk(16, 1, 2, 0, 3));
        wait_iss("to_first_issue", ni + 1);
        core_mode = 0;
        wait_ret("to_retired", 12);
        er = err_cyc;
        chk("to_err_delay",   32'(er - iss_cyc[ni]), 32'(TIMEOUT));
        chk("to_err_sticky",  {31'd0, err_timeout}, 32'd1);
        chk("to_next_issue",  32'(iss_cyc[ni + 1] - iss_cyc[ni]), 32'(TIMEOUT + 3));
        chk("to_wb_count",    32'(n_wb - nw), 32'd1);
        chk("to_wb_addr",     {27'd0, wb_addr[nw]}, 32'd16);
        chk("to_wb_data",     wb_data[nw], 32'd15);
        chk("to_no_r15",      rf[15], 32'd0);

        // rd=0 retires without a write; then a spurious result in IDLE.
        nw = n_wb;
        push(mk(0, 1, 2, 0, 0));
        wait_ret("rd0_retired", 13);
        chk("rd0_no_write", 32'(n_wb - nw), 32'd0);
        ni = n_iss;
        spur = 1'b1;
        tick(2);
        spur = 1'b0;
        tick(3);
        chk("spur_retired", {16'd0, retired}, 32'd13);
        chk("spur_busy",    {31'd0, busy},    32'd0);
        chk("spur_no_issue", 32'(n_iss - ni), 32'd0);
        chk("spur_no_write", 32'(n_wb - nw),  32'd0);
        chk("spur_rd_addr1", {27'd0, rf_rd_addr1}, 32'd0);

        // Reset while in WAIT with one more instruction queued.
        core_mode = 2;
        ni = n_iss; nw = n_wb;
        push(mk(17, 1, 2, 0, 0));
        push(mk(18, 1, 2, 0, 0));
        wait_iss("rstw_issue", ni + 1);
        tick(2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstw_pe_op1",      pe_op1,                32'd0);
        chk("rstw_pe_opcode",   pe_opcode,             32'd0);
        chk("rstw_busy",        {31'd0, busy},         32'd0);
        chk("rstw_retired",     {16'd0, retired},      32'd0);
        chk("rstw_err_timeout", {31'd0, err_timeout},  32'd0);
        chk("rstw_instr_ready", {31'd0, instr_ready},  32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        core_mode = 0;
        tick(30);
        chk("rstw_no_issue", 32'(n_iss - ni), 32'd1);
        chk("rstw_no_write", 32'(n_wb - nw),  32'd0);
        chk("rstw_idle",     {31'd0, busy},   32'd0);

        // Flush with one in flight and three queued, plus a dropped push.
        core_mode = 1;
        ni = n_iss; nw = n_wb;
        push(mk(19, 1, 2, 0, 0));
        push(mk(20, 1, 2, 0, 0));
        push(mk(21, 1, 2, 0, 0));
        push(mk(22, 1, 2, 0, 0));
        flush = 1'b1;
        instr_valid = 1'b1;
        instr_data  = mk(23, 1, 2, 0, 0);
        tick(1);
        flush = 1'b0;
        instr_valid = 1'b0;
        chk("flush_busy",  {31'd0, busy},        32'd1);
        chk("flush_ready", {31'd0, instr_ready}, 32'd1);
        core_mode = 0;
        wait_ret("flush_retired", 1);
        tick(10);
        chk("flush_issue_count", 32'(n_iss - ni), 32'd1);
        chk("flush_wb_count",    32'(n_wb - nw),  32'd1);
        chk("flush_wb_addr",     {27'd0, wb_addr[nw]}, 32'd19);
        chk("flush_wb_data",     wb_data[nw], 32'd12);
        chk("flush_idle",        {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
